bram_stream_reader: RTL
=======================

// Module: bram_stream_reader
// PURPOSE
//  Read-side client for the 2-D block RAM (1-cycle synchronous read). On start it walks a
//  rectangular window (base row/col, row/col counts) row-major and emits each word on a
//  valid/ready stream. Hides the BRAM read latency and absorbs sink backpressure without
//  dropping data. Sits between a BRAM instance and any stream consumer (DMA, compute engine).
// PARAMETERS
//  ROW_ADDR_WIDTH  8   BRAM row address width
//  COL_ADDR_WIDTH  8   BRAM column address width
//  DATA_WIDTH      32  BRAM word / stream data width
// PORTS
//  clk          in   1               single clock, all logic on posedge
//  rst_n        in   1               asynchronous, active-low reset
//  start        in   1               begin transfer; sampled only in IDLE
//  base_row     in   ROW_ADDR_WIDTH  first row; latched on start
//  base_col     in   COL_ADDR_WIDTH  first column; latched on start
//  rows_m1      in   ROW_ADDR_WIDTH  row count minus 1; latched on start
//  cols_m1      in   COL_ADDR_WIDTH  column count minus 1; latched on start
//  busy         out  1               transfer in progress
//  done         out  1               1-cycle pulse: final beat accepted
//  bram_raddr   out  ROW_ADDR_WIDTH  BRAM row address (registered)
//  bram_caddr   out  COL_ADDR_WIDTH  BRAM column address (registered)
//  bram_rdata   in   DATA_WIDTH      BRAM read data, valid 1 cycle after address
//  m_valid      out  1               stream beat valid
//  m_ready      in   1               sink ready
//  m_data       out  DATA_WIDTH      stream data
//  m_last       out  1               final beat of window
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy, done, m_valid, m_last = 0; bram_raddr/caddr = 0;
//    m_data = 0; FIFO and in-flight tracking cleared. Mid-transfer reset discards everything.
//  - FSM: IDLE -(start)-> ISSUE -(last address issued)-> DRAIN -(last beat handshaked)-> IDLE.
//    start in ISSUE/DRAIN is ignored. busy=1 in ISSUE and DRAIN.
//  - Address walk: column inner, row outer; raddr = base_row+r, caddr = base_col+c, each sum
//    wraps modulo 2^width. Total beats = (rows_m1+1)*(cols_m1+1); rows_m1=cols_m1=0 -> 1 beat.
//  - Pipeline: address reg (cycle N) -> BRAM rdata (N+1) -> 4-entry output FIFO (written at end
//    of N+1). Tagged valid shift tracks in-flight reads; last-flag travels with the tag.
//  - Issue rule: new address only if fifo_count + in_flight < 4, so the FIFO never overflows.
//  - Latency: start sampled at edge E -> first address at E+1 -> m_valid high after edge E+3.
//    With m_ready held 1: one beat per cycle, no bubbles after the first beat.
//  - Stream: AXI-style; m_data/m_last stable while m_valid && !m_ready; m_valid never drops
//    without a handshake. Beat accepted on m_valid && m_ready.
//  - done pulses in the cycle after the m_last beat is accepted; busy falls on that same edge.
//    start may be accepted in the cycle done is high (back-to-back transfers).
// CONFIGURATION
//  BRAM_STREAM_READER_ABORT_EN defined: adds input `abort` (1 bit). abort=1 in ISSUE/DRAIN
//    stops issue, drops in-flight reads and FIFO contents, m_valid=0 from next cycle, returns
//    to IDLE; done is NOT pulsed. abort in IDLE has no effect.
//  Not defined: no abort port; transfers run to completion or reset only.
// STRUCTURE
//  - bram_stream_reader_pkg: state_t enum {IDLE, ISSUE, DRAIN}; localparam FIFO_DEPTH = 4.
//  - Sub-module bram_stream_fifo: 4-entry sync FIFO {last, data}, count output, async rst_n.
//  - Top holds FSM, row/col counters, address regs, in-flight tag shift register.
// TESTING
//  1. rst_n=0 mid-transfer -> all outputs 0 immediately; after release, IDLE, no stray beats.
//  2. BRAM mem[r][c]={r,c}; base=(2,3), rows_m1=1, cols_m1=2, m_ready=1 -> 6 beats
//     (2,3),(2,4),(2,5),(3,3),(3,4),(3,5), back-to-back, m_last on 6th, done pulse 1 cycle.
//  3. Same window, m_ready random 50% -> identical data order, no drop/duplication,
//     m_data stable while stalled, addresses never issued with fifo_count+in_flight=4.
//  4. base=(255,254), rows_m1=1, cols_m1=2 -> rows 255,0 / cols 254,255,0 (wrap).
//  5. rows_m1=cols_m1=0 -> single beat with m_last=1; start asserted during DRAIN ignored;
//     start in done cycle launches second transfer, first m_valid 3 edges later.
//  6. (ABORT_EN) abort on 3rd beat of 6 with m_ready=0 -> m_valid 0 next cycle, no done,
//     busy=0, next start reads correct fresh data.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and sizing for the BRAM stream reader.
//   state_t     : transfer FSM states
//   FIFO_DEPTH  : output FIFO entries; also the cap on FIFO occupancy plus reads in flight
//   FIFO_PTR_W  : FIFO pointer width
//   FIFO_CNT_W  : FIFO occupancy counter width (holds 0..FIFO_DEPTH)
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_stream_fifo.sv
// Small synchronous FIFO buffering BRAM read data ahead of the output stream.
// The head entry is presented combinationally (first-word fall-through).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears storage, so rd_data = 0)
//   flush          : synchronous clear of pointers and count
//   wr_en, wr_data : push; the writer guarantees the FIFO is never full when pushing
//   rd_en          : pop the head entry (ignored when empty)
//   rd_data        : head entry
//   count, empty   : current occupancy
module bram_stream_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_rd;

  assign do_rd   = rd_en && (count_q != '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + FIFO_CNT_W'(wr_en) - FIFO_CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a rectangular window of a 1-cycle-latency BRAM row-major (column inner) and emits
// each word on a valid/ready stream, tolerating arbitrary sink backpressure.
// Optional feature: define BRAM_STREAM_READER_ABORT_EN to add the `abort` input, which
// cancels a running transfer (no done pulse, buffered data discarded).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : begin a transfer (sampled only when idle)
//   base_row, base_col         : window origin, latched on start
//   rows_m1, cols_m1           : window size minus one, latched on start
//   abort                      : (BRAM_STREAM_READER_ABORT_EN only) cancel transfer
//   busy, done                 : transfer in progress / 1-cycle completion pulse
//   bram_raddr, bram_caddr     : registered BRAM address
//   bram_rdata                 : BRAM read data, valid one cycle after the address
//   m_valid, m_ready, m_data, m_last : output stream
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ROW_ADDR_WIDTH = 8,
  parameter int unsigned COL_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROW_ADDR_WIDTH-1:0] base_row,
  input  logic [COL_ADDR_WIDTH-1:0] base_col,
  input  logic [ROW_ADDR_WIDTH-1:0] rows_m1,
  input  logic [COL_ADDR_WIDTH-1:0] cols_m1,
`ifdef BRAM_STREAM_READER_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [ROW_ADDR_WIDTH-1:0] bram_raddr,
  output logic [COL_ADDR_WIDTH-1:0] bram_caddr,
  input  logic [DATA_WIDTH-1:0]     bram_rdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last
);

  state_t                    state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] base_row_q, rows_m1_q, r_q, r_d, raddr_q;
  logic [COL_ADDR_WIDTH-1:0] base_col_q, cols_m1_q, c_q, c_d, caddr_q;
  // In-flight tags: stage 1 = address register holds a read, stage 2 = bram_rdata is valid.
  logic                      v1_q, l1_q, v2_q, l2_q;
  logic                      done_q, done_d;
  logic                      load, issue, last_addr, space, beat_acc, abort_hit;
  logic [FIFO_CNT_W-1:0]     fifo_count, occupancy;
  logic                      fifo_empty, head_last;
  logic [DATA_WIDTH-1:0]     head_data;

`ifdef BRAM_STREAM_READER_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_addr = (r_q == rows_m1_q) && (c_q == cols_m1_q);
  // Count reads already issued so buffered + pending data can never exceed the FIFO.
  assign occupancy = fifo_count + FIFO_CNT_W'(v1_q) + FIFO_CNT_W'(v2_q);
  assign space     = occupancy < FIFO_CNT_W'(FIFO_DEPTH);
  assign beat_acc  = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    load    = 1'b0;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          load    = 1'b1;
          r_d     = '0;
          c_d     = '0;
        end
      end
      ISSUE: begin
        if (space) begin
          issue = 1'b1;
          if (last_addr) begin
            state_d = DRAIN;
          end else if (c_q == cols_m1_q) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat_acc && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      issue   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_row_q <= '0;
      base_col_q <= '0;
      rows_m1_q  <= '0;
      cols_m1_q  <= '0;
      r_q        <= '0;
      c_q        <= '0;
      raddr_q    <= '0;
      caddr_q    <= '0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      v2_q       <= 1'b0;
      l2_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      done_q  <= done_d;
      if (load) begin
        base_row_q <= base_row;
        base_col_q <= base_col;
        rows_m1_q  <= rows_m1;
        cols_m1_q  <= cols_m1;
      end
      if (issue) begin
        raddr_q <= base_row_q + r_q;
        caddr_q <= base_col_q + c_q;
      end
      v1_q <= issue;
      l1_q <= issue && last_addr;
      v2_q <= v1_q && !abort_hit;
      l2_q <= l1_q;
    end
  end

  bram_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort_hit),
    .wr_en   (v2_q && !abort_hit),
    .wr_data ({l2_q, bram_rdata}),
    .rd_en   (beat_acc),
    .rd_data ({head_last, head_data}),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign bram_raddr = raddr_q;
  assign bram_caddr = caddr_q;
  assign m_valid    = !fifo_empty;
  assign m_data     = head_data;
  assign m_last     = head_last && !fifo_empty;

endmodule
